// File: rtl/code_lock_seq.sv
// code_lock_seq: multi-digit code lock with a user-changeable code, a failed-attempt
// counter, a timed lockout and automatic relock.
// Optional feature macro: CODE_LOCK_SEQ_LOCKOUT_EN enables fail counting and the LOCKOUT
// state. When it is undefined, lockout is tied low and attempts_left stays at MAX_TRIES.
// All outputs come straight from registers; a completed entry shows up one cycle after
// the edge that accepts its last digit.
module code_lock_seq #(
    parameter int unsigned DIGIT_W        = 4,
    parameter int unsigned CODE_LEN       = 4,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned RELOCK_CYCLES  = 15,
    parameter int unsigned LOCKOUT_CYCLES = 15,
    parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE = 16'h1234
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DIGIT_W-1:0]             digit,
    input  logic                           digit_valid,
    input  logic                           clear,
    input  logic                           lock_req,
    input  logic                           set_req,
    output logic                           locked,
    output logic                           unlocked,
    output logic                           lockout,
    output logic                           set_mode,
    output logic [$clog2(MAX_TRIES+1)-1:0] attempts_left,
    output logic                           err_pulse,
    output logic                           set_done
);

    localparam int unsigned CODE_W  = DIGIT_W * CODE_LEN;
    localparam int unsigned CNT_W   = $clog2(CODE_LEN + 1);
    localparam int unsigned ATT_W   = $clog2(MAX_TRIES + 1);
    localparam int unsigned TMR_MAX = (RELOCK_CYCLES > LOCKOUT_CYCLES) ? RELOCK_CYCLES
                                                                       : LOCKOUT_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(CODE_LEN - 1);
    localparam logic [ATT_W-1:0] MAX_ATT      = ATT_W'(MAX_TRIES);
    localparam logic [TMR_W-1:0] RELOCK_LAST  = TMR_W'(RELOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCKOUT_LAST = TMR_W'(LOCKOUT_CYCLES - 1);

    // One-hot encoding so each indicator output is a single state flop.
    typedef enum logic [3:0] {
        StLocked   = 4'b0001,
        StUnlocked = 4'b0010,
        StSet      = 4'b0100,
        StLockout  = 4'b1000
    } state_e;

    state_e              r_state;
    logic [CODE_W-1:0]   r_code;
    logic [CODE_W-1:0]   r_buf;
    logic [CNT_W-1:0]    r_cnt;
    logic [TMR_W-1:0]    r_timer;
    logic [ATT_W-1:0]    r_att;
    logic                r_err;
    logic                r_set_done;

    state_e              w_state_d;
    logic [CODE_W-1:0]   w_code_d;
    logic [CODE_W-1:0]   w_buf_d;
    logic [CNT_W-1:0]    w_cnt_d;
    logic [TMR_W-1:0]    w_timer_d;
    logic [ATT_W-1:0]    w_att_d;
    logic                w_err_d;
    logic                w_set_done_d;
    logic [CODE_W-1:0]   w_entry;
    logic                w_last;

    // Next-state, entry buffer, timer and attempt bookkeeping.
    always_comb begin
        w_state_d    = r_state;
        w_code_d     = r_code;
        w_buf_d      = r_buf;
        w_cnt_d      = r_cnt;
        w_timer_d    = r_timer;
        w_att_d      = r_att;
        w_err_d      = 1'b0;
        w_set_done_d = 1'b0;
        // Buffer contents including the digit being strobed this cycle.
        w_entry      = (r_buf << DIGIT_W) | CODE_W'(digit);
        w_last       = (r_cnt == LAST_CNT);

        unique case (r_state)
            StLocked: begin
                w_timer_d = '0;
                if (lock_req || clear) begin
                    w_buf_d = '0;
                    w_cnt_d = '0;
                end else if (digit_valid) begin
                    if (w_last) begin
                        w_buf_d = '0;
                        w_cnt_d = '0;
                        if (w_entry == r_code) begin
                            w_state_d = StUnlocked;
                            w_att_d   = MAX_ATT;
                        end else begin
                            w_err_d = 1'b1;
`ifdef CODE_LOCK_SEQ_LOCKOUT_EN
                            // Saturate at zero attempts; reaching zero starts the lockout.
                            if (r_att <= ATT_W'(1)) begin
                                w_att_d   = '0;
                                w_state_d = StLockout;
                            end else begin
                                w_att_d = r_att - 1'b1;
                            end
`endif
                        end
                    end else begin
                        w_buf_d = w_entry;
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
            end

            StUnlocked: begin
                // Digits and clear have nothing to act on here and do not hold off relock.
                if (lock_req) begin
                    w_state_d = StLocked;
                    w_buf_d   = '0;
                    w_cnt_d   = '0;
                    w_timer_d = '0;
                end else if (set_req) begin
                    w_state_d = StSet;
                    w_timer_d = '0;
                end else if (r_timer == RELOCK_LAST) begin
                    w_state_d = StLocked;
                    w_timer_d = '0;
                end else begin
                    w_timer_d = r_timer + 1'b1;
                end
            end

            StSet: begin
                if (lock_req) begin
                    w_state_d = StLocked;
                    w_buf_d   = '0;
                    w_cnt_d   = '0;
                    w_timer_d = '0;
                end else if (clear) begin
                    w_state_d = StUnlocked;
                    w_buf_d   = '0;
                    w_cnt_d   = '0;
                    w_timer_d = '0;
                end else if (digit_valid) begin
                    if (w_last) begin
                        w_code_d     = w_entry;
                        w_set_done_d = 1'b1;
                        w_state_d    = StUnlocked;
                        w_buf_d      = '0;
                        w_cnt_d      = '0;
                        w_timer_d    = '0;
                    end else begin
                        w_buf_d = w_entry;
                        w_cnt_d = r_cnt + 1'b1;
                        // A digit outranks expiry; hold at the limit so it fires next cycle.
                        if (r_timer != RELOCK_LAST) begin
                            w_timer_d = r_timer + 1'b1;
                        end
                    end
                end else if (r_timer == RELOCK_LAST) begin
                    w_state_d = StLocked;
                    w_buf_d   = '0;
                    w_cnt_d   = '0;
                    w_timer_d = '0;
                end else begin
                    w_timer_d = r_timer + 1'b1;
                end
            end

            StLockout: begin
                if (r_timer == LOCKOUT_LAST) begin
                    w_state_d = StLocked;
                    w_att_d   = MAX_ATT;
                    w_timer_d = '0;
                end else begin
                    w_timer_d = r_timer + 1'b1;
                end
            end

            default: begin
                w_state_d = StLocked;
                w_buf_d   = '0;
                w_cnt_d   = '0;
                w_timer_d = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StLocked;
            r_code     <= DEFAULT_CODE;
            r_buf      <= '0;
            r_cnt      <= '0;
            r_timer    <= '0;
            r_att      <= MAX_ATT;
            r_err      <= 1'b0;
            r_set_done <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_code     <= w_code_d;
            r_buf      <= w_buf_d;
            r_cnt      <= w_cnt_d;
            r_timer    <= w_timer_d;
            r_att      <= w_att_d;
            r_err      <= w_err_d;
            r_set_done <= w_set_done_d;
        end
    end

    assign locked        = r_state[0];
    assign unlocked      = r_state[1];
    assign set_mode      = r_state[2];
`ifdef CODE_LOCK_SEQ_LOCKOUT_EN
    assign lockout       = r_state[3];
`else
    assign lockout       = 1'b0;
`endif
    assign attempts_left = r_att;
    assign err_pulse     = r_err;
    assign set_done      = r_set_done;

endmodule

// File: doc/code_lock_seq.md
# code_lock_seq

Parametrised multi-digit code lock, the next generation of the single-switch lock FSM. It accepts a sequence of debounced digit strobes, compares the completed entry against a stored, user-changeable code, and tracks failed attempts. It enforces a configurable lockout and auto-relock, and sits between the button/switch debounce front end and the LED/actuator drivers.

## Interface
Parameters:
- DIGIT_W, 4: bits per digit.
- CODE_LEN, 4: digits per code, at least 1.
- MAX_TRIES, 3: consecutive wrong entries that trigger lockout, at least 1.
- RELOCK_CYCLES, 15: cycles spent in UNLOCKED or SET before the block relocks automatically, at least 1.
- LOCKOUT_CYCLES, 15: cycles spent in LOCKOUT, at least 1.
- DEFAULT_CODE, 16'h1234: reset value of the stored code, DIGIT_W*CODE_LEN bits wide. The first digit entered is the most significant.

Ports (one clock; reset is synchronous and active-high):
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- digit, in, DIGIT_W: digit value, sampled only when digit_valid is high.
- digit_valid, in, 1: single-cycle strobe, already debounced upstream.
- clear, in, 1: discard the partial entry.
- lock_req, in, 1: manual lock.
- set_req, in, 1: enter code-change mode (honoured only in UNLOCKED).
- locked, unlocked, lockout, set_mode, out, 1 each: one-hot state indicators.
- attempts_left, out, $clog2(MAX_TRIES+1): equals MAX_TRIES minus the current fail count.
- err_pulse, out, 1: one cycle, wrong code entered.
- set_done, out, 1: one cycle, new code stored.

## Operation
- States: LOCKED, UNLOCKED, SET, LOCKOUT. All outputs are registered.
- Entry buffer: each digit_valid shifts the buffer left by DIGIT_W and inserts digit; the digit count increments.
- Code check: on the digit_valid that makes count reach CODE_LEN, the comparison uses the buffer including the current digit. The count and buffer clear in the same cycle.
- LOCKED, match: go to UNLOCKED, fail count becomes 0.
- LOCKED, mismatch: err_pulse, fail count increments. When the new count equals MAX_TRIES, go to LOCKOUT.
- UNLOCKED: set_req moves to SET and restarts the timer. digit_valid is ignored. Timer expiry moves to LOCKED.
- SET: collects CODE_LEN digits. On the last digit the stored code takes the new value, set_done pulses, and the state returns to UNLOCKED with the timer restarted.
- SET, clear: aborts to UNLOCKED with the code unchanged.
- SET, timer expiry: moves to LOCKED with the code unchanged.
- LOCKOUT: all inputs except rst are ignored. On expiry, go to LOCKED with fail count 0.
- Priority within a cycle is rst > lock_req > clear > digit_valid > set_req > timer expiry.
- lock_req in LOCKOUT is ignored. In every other state it moves to LOCKED and clears the buffer and count; the fail count is unchanged.
- clear in LOCKED empties the buffer without counting a failure.

## Timing
- Reset values:
  - state LOCKED, so locked is 1 and unlocked, lockout, set_mode are 0.
  - stored code is DEFAULT_CODE.
  - attempts_left is MAX_TRIES.
  - err_pulse and set_done are 0.
  - buffer, count and timer are 0.
- A reset in the middle of an entry or a code change discards it and restores DEFAULT_CODE.
- Latency: the final digit is accepted at edge N. The state indicators, err_pulse and attempts_left reflect the result from edge N+1.
- Timer:
  - Cleared on entry to UNLOCKED, SET and LOCKOUT.
  - Increments once per cycle while in those states.
  - Expiry occurs when the timer equals the state's limit minus 1.
  - UNLOCKED and SET therefore last exactly RELOCK_CYCLES cycles; LOCKOUT lasts exactly LOCKOUT_CYCLES cycles.
- Timer and counter widths: $clog2 of the maximum value plus 1. No wrap-around is possible.
- The fail count saturates at MAX_TRIES and does not wrap.

## Configuration
- CODE_LOCK_SEQ_LOCKOUT_EN defined: the LOCKOUT state and fail counting behave as described above.
- Not defined:
  - LOCKOUT is never entered and the lockout output is tied to 0.
  - The fail count stays 0, so attempts_left is always MAX_TRIES.
  - err_pulse still fires on every wrong code.

## Test plan
Defaults apart from RELOCK_CYCLES=8 and LOCKOUT_CYCLES=6, macro defined.
- Enter 1,2,3,4 -> unlocked rises 1 cycle after the 4th strobe, falls exactly 8 cycles later, and locked returns to 1.
- Enter 1,2,3,5 three times -> err_pulse three times, attempts_left goes 2, 1, 0, lockout=1 for 6 cycles, then locked with attempts_left=3.
- Unlock, set_req, enter 9,8,7,6 -> set_done pulses. lock_req, then 1,2,3,4 -> err_pulse. 9,8,7,6 -> unlocked.
- Enter 1,2, then clear, then 3,4,1,2 -> err_pulse, because the buffer holds 3412 and not 1234.
- In SET, enter 5,5, then let 8 cycles elapse -> locked, and the code is still 1234.
- Assert rst while in LOCKOUT and in SET -> locked=1, attempts_left=3, and 1,2,3,4 unlocks.
